// File: rtl/dmem_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : dmem_pkg
// Brief  : Shared types and lane helpers for the data-memory responder.
// Rev    : 1.0  initial release
// ----------------------------------------------------------------------------
package dmem_pkg;

  // Access size as presented on req_size; encoding 3 is an illegal size
  typedef enum logic [1:0] {
    BYTE = 2'd0,
    HALF = 2'd1,
    WORD = 2'd2
  } size_t;

  // Responder transaction state
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Byte enables for an access of the given size starting at byte lane off
  function automatic logic [3:0] byte_en(input size_t size, input logic [1:0] off);
    logic [3:0] be;
    case (size)
      BYTE:    be = 4'b0001 << off;
      HALF:    be = 4'b0011 << off;
      WORD:    be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  // Move right-aligned store data up into its byte lane
  function automatic logic [31:0] lane_shl(input logic [31:0] d, input logic [1:0] off);
    return d << {off, 3'b000};
  endfunction

  // Move a loaded byte lane down to bit 0
  function automatic logic [31:0] lane_shr(input logic [31:0] d, input logic [1:0] off);
    return d >> {off, 3'b000};
  endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_array.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : dmem_array
// Brief  : DEPTH x 32 single-port RAM, synchronous read, per-byte write enable.
// Rev    : 1.0  initial release
// ----------------------------------------------------------------------------
module dmem_array #(
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic          clk,
  input  logic [3:0]    we,
  input  logic          re,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] r_mem [DEPTH];
  logic [31:0] r_rdata;

  // Byte-masked write and registered read; read data holds while re is low
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (we[b]) r_mem[addr][8*b +: 8] <= wdata[8*b +: 8];
    end
    if (re) r_rdata <= r_mem[addr];
  end

  assign rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : dmem_responder
// Brief  : Load/store responder with configurable wait states, byte-lane
//          stores, sign/zero-extended loads and out-of-range fault flagging.
//          Build option: DMEM_MISALIGN_TRAP_EN turns misaligned HALF/WORD
//          accesses into faults instead of aligning them down.
// Rev    : 1.0  initial release
// ----------------------------------------------------------------------------
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int          DEPTH     = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0000_2000,
  parameter int          LATENCY   = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  size_t       req_size,
  input  logic        req_unsigned,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int              c_aw       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int              c_cw       = $clog2(LATENCY + 1);
  localparam logic [c_cw-1:0] c_cnt_init = (LATENCY > 1) ? c_cw'(LATENCY - 2) : '0;
  localparam bit              c_single   = (LATENCY == 1);

  state_t          r_state, w_next;
  logic [c_cw-1:0] r_count;
  logic            r_we, r_unsigned, r_err;
  size_t           r_size;
  logic [1:0]      r_off;
  logic [c_aw-1:0] r_idx;

  logic [31:0]     w_offset;
  logic [1:0]      w_off_lo;
  logic            w_range_err, w_size_err, w_align_err, w_fault;
  logic            w_accept, w_enter_resp;
  logic [3:0]      w_be;
  logic [c_aw-1:0] w_addr;
  logic [31:0]     w_rdata, w_lane, w_ext;

  // Offset wraps, so addresses below BASE_ADDR land far out of range
  assign w_offset    = req_addr - BASE_ADDR;
  assign w_range_err = {2'b00, w_offset[31:2]} >= 32'(DEPTH);
  assign w_size_err  = (req_size != BYTE) && (req_size != HALF) && (req_size != WORD);

`ifdef DMEM_MISALIGN_TRAP_EN
  assign w_align_err = ((req_size == HALF) && w_offset[0]) ||
                       ((req_size == WORD) && (w_offset[1:0] != 2'b00));
  assign w_off_lo    = w_offset[1:0];
`else
  assign w_align_err = 1'b0;
  assign w_off_lo    = (req_size == HALF) ? {w_offset[1], 1'b0} :
                       (req_size == WORD) ? 2'b00 : w_offset[1:0];
`endif

  assign w_fault  = w_range_err | w_size_err | w_align_err;
  assign w_accept = (r_state == IDLE) && req_valid;

  // Next state and handshake outputs; req_ready depends on state alone
  always_comb begin
    w_next    = r_state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    case (r_state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) w_next = c_single ? RESP : WAIT;
      end
      WAIT: begin
        if (r_count == '0) w_next = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Request capture at acceptance and wait-state countdown
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_count    <= '0;
      r_err      <= 1'b0;
      r_we       <= 1'b0;
      r_unsigned <= 1'b0;
      r_size     <= BYTE;
      r_off      <= 2'b00;
      r_idx      <= '0;
    end else if (w_accept) begin
      r_count    <= c_cnt_init;
      r_err      <= w_fault;
      r_we       <= req_we;
      r_unsigned <= req_unsigned;
      r_size     <= req_size;
      r_off      <= w_off_lo;
      r_idx      <= w_offset[c_aw+1:2];
    end else if ((r_state == WAIT) && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  // Stores hit the array on the acceptance edge; loads read on the edge into RESP.
  // With a single wait state those are the same edge, so address from the live request.
  assign w_enter_resp = (w_next == RESP) && (r_state != RESP);
  assign w_be         = (w_accept && req_we && !w_fault) ? byte_en(req_size, w_off_lo) : 4'b0000;
  assign w_addr       = (r_state == IDLE) ? w_offset[c_aw+1:2] : r_idx;

  dmem_array #(
    .DEPTH (DEPTH),
    .AW    (c_aw)
  ) u_array (
    .clk   (clk),
    .we    (w_be),
    .re    (w_enter_resp),
    .addr  (w_addr),
    .wdata (lane_shl(req_wdata, w_off_lo)),
    .rdata (w_rdata)
  );

  // Align the loaded lane to bit 0 and extend to 32 bits
  assign w_lane = lane_shr(w_rdata, r_off);
  always_comb begin
    w_ext = w_rdata;
    case (r_size)
      BYTE:    w_ext = r_unsigned ? {24'h0, w_lane[7:0]}  : {{24{w_lane[7]}}, w_lane[7:0]};
      HALF:    w_ext = r_unsigned ? {16'h0, w_lane[15:0]} : {{16{w_lane[15]}}, w_lane[15:0]};
      default: w_ext = w_rdata;
    endcase
  end

  assign rsp_rdata = ((r_state == RESP) && !r_we && !r_err) ? w_ext : 32'h0;
  assign rsp_err   = (r_state == RESP) && r_err;

endmodule
`default_nettype wire

// File: doc/dmem_responder.md
# dmem_responder

Memory-side responder for the core's load/store port: accepts one request at a time from the datapath side (address, store data, size, write enable) and returns a response after a configurable number of wait states. Holds a byte-addressable, little-endian data array, performs byte/half/word stores with byte enables, sign- or zero-extends loads, and flags out-of-range accesses. Sits between the core's datapath and the data-memory address space as the replacement for the ideal zero-latency data memory.

## Interface

Parameters:
- DEPTH, 1024: number of 32-bit words in the array; power of two.
- BASE_ADDR, 32'h0000_2000: byte address of word 0; word-aligned.
- LATENCY, 1: cycles from acceptance edge to response; integer ≥ 1.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  responder can accept a request
- req_we  in  1  1 = store, 0 = load
- req_addr  in  32  byte address (from ALUResult)
- req_wdata  in  32  store data (from WriteData), right-aligned
- req_size  in  2  access size, dmem_pkg::size_t
- req_unsigned  in  1  zero-extend loads (LBU/LHU)
- rsp_valid  out  1  response present
- rsp_ready  in  1  requester takes response
- rsp_rdata  out  32  extended load data; 0 for stores and errors
- rsp_err  out  1  access fault

## Operation

- FSM states IDLE, WAIT, RESP.
- IDLE: req_ready = 1. On req_valid: capture request, count = LATENCY−2, go to RESP if LATENCY == 1, else WAIT.
- WAIT: if count == 0 go to RESP, else decrement. req_ready = 0.
- RESP: rsp_valid = 1; rsp_rdata/rsp_err held stable until rsp_ready = 1, then back to IDLE. No new request accepted in the same cycle.
- offset = req_addr − BASE_ADDR (32-bit, wrapping). Fault if offset[31:2] ≥ DEPTH (covers addresses below BASE_ADDR via wrap).
- Sizes: BYTE = 0, HALF = 1, WORD = 2; value 3 is a fault.
- Store: written on the acceptance edge; byte enables from size and offset[1:0]; data lane-shifted by offset[1:0]×8. No write on fault.
- Load: word read on the edge entering RESP, lane-shifted right by offset[1:0]×8, then extended from bit 7 or 15 unless req_unsigned. WORD ignores req_unsigned.
- On fault: rsp_err = 1, rsp_rdata = 0, array unchanged.
- Array contents not reset.

## Timing

- Reset (reset = 0 at an edge): state IDLE, count 0; req_ready = 1 from the following cycle; rsp_valid = 0, rsp_rdata = 0, rsp_err = 0.
- Reset mid-transaction abandons it: no response. A store already accepted stays written.
- Accept on edge k ⇒ rsp_valid first high in the cycle after edge k+LATENCY−1.
- Throughput with rsp_ready tied high: one request per LATENCY+1 cycles.
- req_ready depends only on state, never on req_valid, so there is no combinational path from req_valid to req_ready.
- Request inputs are sampled only at the acceptance edge; later changes are ignored.

## Configuration

- DMEM_MISALIGN_TRAP_EN defined: a HALF access with offset[0] ≠ 0, or a WORD access with offset[1:0] ≠ 0, is a fault (rsp_err = 1, no write, rdata 0).
- DMEM_MISALIGN_TRAP_EN undefined: no misalignment fault. offset is aligned down to the access size (HALF clears bit 0, WORD clears bits 1:0), then the access proceeds normally.

## Structure

- dmem_pkg holds:
  - size_t enum (BYTE, HALF, WORD)
  - state_t enum (IDLE, WAIT, RESP)
  - byte-enable and lane-shift helper functions
- Sub-module dmem_array: DEPTH×32 synchronous-read RAM with 4 byte write enables, one read/write port.
- FSM, address check and extension live in dmem_responder.

## Test plan

- Reset, LATENCY = 1: store WORD 0xDEADBEEF at 0x2000, then load WORD at 0x2000 → rsp_valid one cycle after each accept; rdata 0xDEADBEEF; err 0.
- Store BYTE 0x80 at 0x2003, then load BYTE signed and unsigned at 0x2003 → 0xFFFFFF80 and 0x00000080; word at 0x2000 reads 0x80ADBEEF.
- LATENCY = 4, rsp_ready held low 3 cycles after rsp_valid:
  - rsp_valid rises after edge k+3;
  - rdata stable while held;
  - req_ready stays 0 until the cycle after the handshake.
- Load at 0x1FFC and at BASE_ADDR + 4×DEPTH → err 1, rdata 0; an out-of-range store leaves the array unchanged on readback.
- HALF load at 0x2001:
  - with DMEM_MISALIGN_TRAP_EN → err 1;
  - without it → reads the half at 0x2000 (0xFFFFBEEF signed), err 0.
- Drive reset low during WAIT (LATENCY = 4) → no rsp_valid; req_ready = 1 after release; next request completes normally.
